// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - producer/consumer and status bundle for sync_fifo_prog
interface sync_fifo_prog_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  clr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] din;
    logic                  ren;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic [ADDR_WIDTH:0]   afull_lvl;
    logic [ADDR_WIDTH:0]   aempty_lvl;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  alfull;
    logic                  alempty;
    logic                  ovf;
    logic                  udf;
    logic                  err_clr;

    modport master (
        output clr, wen, din, ren, afull_lvl, aempty_lvl, err_clr,
        input  dout, dout_vld, count, full, empty, alfull, alempty, ovf, udf
    );

    modport slave (
        input  clr, wen, din, ren, afull_lvl, aempty_lvl, err_clr,
        output dout, dout_vld, count, full, empty, alfull, alempty, ovf, udf
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds, sticky errors and FWFT option
module sync_fifo_prog #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit FWFT       = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_prog_if.slave f
);
    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                full_w, empty_w;
    logic                wr_acc, rd_acc;

    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    // Flush masks both requests, so it can neither move data nor raise an error flag.
    assign wr_acc = f.wen & ~full_w  & ~f.clr;
    assign rd_acc = f.ren & ~empty_w & ~f.clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = f.err_clr ? 1'b0 : ovf_q;
        udf_d   = f.err_clr ? 1'b0 : udf_q;
        if (f.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + ONE;
            if (rd_acc) rptr_d = rptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            if (f.wen && full_w)  ovf_d = 1'b1;
            if (f.ren && empty_w) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr_q[ADDR_WIDTH-1:0]] <= f.din;
    end

    generate
        if (FWFT) begin : g_fwft
            assign f.dout     = mem[rptr_q[ADDR_WIDTH-1:0]];
            assign f.dout_vld = ~empty_w;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dout_vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q     <= '0;
                    dout_vld_q <= 1'b0;
                end else if (f.clr) begin
                    dout_q     <= '0;
                    dout_vld_q <= 1'b0;
                end else begin
                    dout_vld_q <= rd_acc;
                    if (rd_acc) dout_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
                end
            end

            assign f.dout     = dout_q;
            assign f.dout_vld = dout_vld_q;
        end
    endgenerate

    assign f.count   = count_q;
    assign f.full    = full_w;
    assign f.empty   = empty_w;
    assign f.alfull  = (count_q >= f.afull_lvl);
    assign f.alempty = (count_q <= f.aempty_lvl);
    assign f.ovf     = ovf_q;
    assign f.udf     = udf_q;
endmodule
